// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register file write-port arbiter with src1 buffering, WAW kill and forwarding
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     src0_valid,
  input  logic [AW-1:0]            src0_addr,
  input  logic [DW-1:0]            src0_data,
  input  logic                     src1_valid,
  output logic                     src1_ready,
  input  logic [AW-1:0]            src1_addr,
  input  logic [DW-1:0]            src1_data,
  output logic                     we,
  output logic [AW-1:0]            rdc,
  output logic [DW-1:0]            rd,
  input  logic [AW-1:0]            rsc,
  input  logic [AW-1:0]            rtc,
  output logic                     rs_hit,
  output logic [DW-1:0]            rs_fwd,
  output logic                     rt_hit,
  output logic [DW-1:0]            rt_fwd,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;

  logic src0_w, src1_acc, src1_w, fifo_empty, do_pop, do_push, bypass;

  assign pending    = count;
  assign src1_ready = (count < (PW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign src0_w     = src0_valid && (src0_addr != '0);
  assign src1_acc   = src1_valid && src1_ready;
  // src0 is younger than any src1 result, so a same-address src1 is already dead
  assign src1_w     = src1_acc && (src1_addr != '0) && !(src0_w && (src0_addr == src1_addr));
  assign do_pop     = !src0_w && !fifo_empty;
  assign bypass     = !src0_w && fifo_empty && src1_w;
  assign do_push    = src1_w && !bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we       <= 1'b0;
      rdc      <= '0;
      rd       <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (src0_w) begin
        we  <= 1'b1;
        rdc <= src0_addr;
        rd  <= src0_data;
      end else if (do_pop) begin
        we <= ent_live[head];
        if (ent_live[head]) begin
          rdc <= ent_addr[head];
          rd  <= ent_data[head];
        end
      end else if (bypass) begin
        we  <= 1'b1;
        rdc <= src1_addr;
        rd  <= src1_data;
      end else begin
        we <= 1'b0;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (src0_w && ent_addr[i] == src0_addr) ent_live[i] <= 1'b0;
      end

      if (do_pop) begin
        ent_live[head] <= 1'b0;
        head           <= head + 1'b1;
      end

      if (do_push) begin
        ent_addr[tail] <= src1_addr;
        ent_data[tail] <= src1_data;
        ent_live[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end

      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  logic [PW-1:0] idx;

  // Scan oldest to youngest so the youngest live match overrides; live bits exist only in occupied slots
  always_comb begin
    rs_hit = 1'b0;
    rs_fwd = '0;
    rt_hit = 1'b0;
    rt_fwd = '0;
    idx    = '0;
    if (we && rdc == rsc && rsc != '0) begin
      rs_hit = 1'b1;
      rs_fwd = rd;
    end
    if (we && rdc == rtc && rtc != '0) begin
      rt_hit = 1'b1;
      rt_fwd = rd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_live[idx] && ent_addr[idx] == rsc && rsc != '0) begin
        rs_hit = 1'b1;
        rs_fwd = ent_data[idx];
      end
      if (ent_live[idx] && ent_addr[idx] == rtc && rtc != '0) begin
        rt_hit = 1'b1;
        rt_fwd = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - directed self-checking bench for wb_write_arbiter
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src0_valid, src1_valid, src1_ready;
  logic [4:0]  src0_addr, src1_addr, rdc, rsc, rtc;
  logic [31:0] src0_data, src1_data, rd, rs_fwd, rt_fwd;
  logic        we, rs_hit, rt_hit;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  wb_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_valid(src0_valid), .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_addr(src1_addr), .src1_data(src1_data),
    .we(we), .rdc(rdc), .rd(rd),
    .rsc(rsc), .rtc(rtc),
    .rs_hit(rs_hit), .rs_fwd(rs_fwd), .rt_hit(rt_hit), .rt_fwd(rt_fwd),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src0_valid = 1'b0; src0_addr = '0; src0_data = '0;
    src1_valid = 1'b0; src1_addr = '0; src1_data = '0;
  endtask

  task automatic s0(input int a, input int d);
    src0_valid = 1'b1; src0_addr = 5'(a); src0_data = 32'(d);
  endtask

  task automatic s1(input int a, input int d);
    src1_valid = 1'b1; src1_addr = 5'(a); src1_data = 32'(d);
  endtask

  task automatic wr(input string tag, input int a, input int d);
    chk({tag, "_we"}, {31'd0, we}, 32'd1);
    chk({tag, "_rdc"}, {27'd0, rdc}, 32'(a));
    chk({tag, "_rd"}, rd, 32'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rsc = '0; rtc = '0;
    repeat (2) tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_rdc", {27'd0, rdc}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    chk("rst_pending", {29'd0, pending}, 32'd0);
    chk("rst_ready", {31'd0, src1_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // bypass
    s1(5, 32'hDEADBEEF);
    chk("byp_ready", {31'd0, src1_ready}, 32'd1);
    tick();
    idle();
    wr("byp", 5, 32'hDEADBEEF);
    chk("byp_pending", {29'd0, pending}, 32'd0);
    rsc = 5'd5;
    #1;
    chk("byp_rs_hit", {31'd0, rs_hit}, 32'd1);
    chk("byp_rs_fwd", rs_fwd, 32'hDEADBEEF);
    tick();
    chk("byp_idle_we", {31'd0, we}, 32'd0);
    chk("byp_hold_rd", rd, 32'hDEADBEEF);
    chk("byp_idle_hit", {31'd0, rs_hit}, 32'd0);

    // register 0
    s0(0, 5); s1(0, 6);
    tick();
    idle();
    rsc = '0;
    #1;
    chk("r0_we", {31'd0, we}, 32'd0);
    chk("r0_pending", {29'd0, pending}, 32'd0);
    chk("r0_rs_hit", {31'd0, rs_hit}, 32'd0);

    // contention / full: src1 accepts 9..12, stalls at pending=4
    for (int k = 1; k <= 8; k++) begin
      s0(k, 32'h100 + k);
      if (k <= 4) s1(8 + k, 32'h200 + 8 + k);
      else        s1(13, 32'h20D);
      chk($sformatf("cont_ready_%0d", k), {31'd0, src1_ready}, (k <= 4) ? 32'd1 : 32'd0);
      tick();
      wr($sformatf("cont_%0d", k), k, 32'h100 + k);
    end
    chk("cont_pending_full", {29'd0, pending}, 32'd4);
    rsc = 5'd10; rtc = 5'd8;
    #1;
    chk("cont_rs_hit", {31'd0, rs_hit}, 32'd1);
    chk("cont_rs_fwd", rs_fwd, 32'h20A);
    chk("cont_rt_hit", {31'd0, rt_hit}, 32'd1);
    chk("cont_rt_fwd", rt_fwd, 32'h108);
    src0_valid = 1'b0;
    chk("drain_ready0", {31'd0, src1_ready}, 32'd0);
    tick();
    wr("drain9", 9, 32'h209);
    chk("drain9_pending", {29'd0, pending}, 32'd3);
    chk("drain_ready1", {31'd0, src1_ready}, 32'd1);
    tick();
    wr("drain10", 10, 32'h20A);
    chk("drain10_pending", {29'd0, pending}, 32'd3);
    s1(14, 32'h20E);
    tick();
    src1_valid = 1'b0;
    wr("drain11", 11, 32'h20B);
    tick();
    wr("drain12", 12, 32'h20C);
    chk("drain12_pending", {29'd0, pending}, 32'd2);
    tick();
    wr("drain13", 13, 32'h20D);
    tick();
    wr("drain14", 14, 32'h20E);
    chk("drain_empty", {29'd0, pending}, 32'd0);

    // WAW kill
    s0(2, 32'h33); s1(7, 32'h11);
    tick();
    idle();
    rsc = 5'd7; rtc = '0;
    #1;
    chk("waw_buf_hit", {31'd0, rs_hit}, 32'd1);
    chk("waw_buf_fwd", rs_fwd, 32'h11);
    s0(7, 32'h22);
    tick();
    idle();
    wr("waw_out", 7, 32'h22);
    chk("waw_pending", {29'd0, pending}, 32'd1);
    chk("waw_fwd_out", rs_fwd, 32'h22);
    tick();
    chk("waw_killed_we", {31'd0, we}, 32'd0);
    chk("waw_killed_rd", rd, 32'h22);
    chk("waw_killed_pending", {29'd0, pending}, 32'd0);
    chk("waw_killed_hit", {31'd0, rs_hit}, 32'd0);

    // same-cycle collision
    s0(3, 32'hA); s1(3, 32'hB);
    chk("col_ready", {31'd0, src1_ready}, 32'd1);
    tick();
    idle();
    wr("col", 3, 32'hA);
    chk("col_pending", {29'd0, pending}, 32'd0);
    tick();
    chk("col_after_we", {31'd0, we}, 32'd0);

    // youngest FIFO entry wins forwarding
    s0(1, 32'h1); s1(6, 32'h61);
    tick();
    s0(2, 32'h2); s1(6, 32'h62);
    tick();
    idle();
    rsc = 5'd6; rtc = 5'd2;
    #1;
    chk("young_rs_fwd", rs_fwd, 32'h62);
    chk("young_rt_fwd", rt_fwd, 32'h2);
    tick();
    wr("young_d0", 6, 32'h61);
    chk("young_rs_fwd2", rs_fwd, 32'h62);
    tick();
    wr("young_d1", 6, 32'h62);

    // pointer wrap: 10 rounds of two pushes then two pops
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 2; j++) begin
        s0(1, 32'h77);
        s1(16 + (r * 2 + j) % 15, 32'h1000 + r * 2 + j);
        tick();
      end
      idle();
      for (int j = 0; j < 2; j++) begin
        tick();
        wr($sformatf("wrap_%0d_%0d", r, j), 16 + (r * 2 + j) % 15, 32'h1000 + r * 2 + j);
      end
    end
    chk("wrap_pending", {29'd0, pending}, 32'd0);

    // asynchronous reset mid-drain
    for (int j = 0; j < 3; j++) begin
      s0(1, 32'h5); s1(20 + j, 32'h300 + j);
      tick();
    end
    idle();
    chk("mid_pending", {29'd0, pending}, 32'd3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_pending", {29'd0, pending}, 32'd0);
    chk("mid_rst_ready", {31'd0, src1_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("post_rst_we_%0d", j), {31'd0, we}, 32'd0);
    end
    chk("post_rst_pending", {29'd0, pending}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
